// File: rtl/pacman_soc_pio_pkg.sv
// Shared definitions for the SoC PIO blocks: register word addresses and edge selection.
package pacman_soc_pio_pkg;

  localparam logic [1:0] PIO_ADDR_DATA    = 2'd0;
  localparam logic [1:0] PIO_ADDR_RSVD    = 2'd1;
  localparam logic [1:0] PIO_ADDR_IRQMASK = 2'd2;
  localparam logic [1:0] PIO_ADDR_EDGECAP = 2'd3;

  typedef enum logic [1:0] {
    EDGE_RISING  = 2'd0,
    EDGE_FALLING = 2'd1,
    EDGE_ANY     = 2'd2
  } edge_type_e;

  function automatic logic edge_hit(input logic prev, input logic cur, input edge_type_e et);
    logic hit;
    case (et)
      EDGE_RISING:  hit = ~prev & cur;
      EDGE_FALLING: hit = prev & ~cur;
      EDGE_ANY:     hit = prev ^ cur;
      default:      hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/pacman_soc_pio_debounce.sv
// One input bit: two-flop synchroniser followed by a stable-count debouncer.
module pacman_soc_pio_debounce #(
  parameter int   DEBOUNCE_CYCLES = 16,
  parameter logic RESET_LEVEL     = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic in_bit_i,
  output logic state_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          state_q;
  logic [CW-1:0] cnt_q;

  // Counter only advances while the synchronised input disagrees with the state,
  // so it is cleared before it could ever pass CNT_LAST.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
      state_q <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      sync1_q <= in_bit_i;
      sync2_q <= sync1_q;
      if (sync2_q == state_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CNT_LAST) begin
        state_q <= sync2_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/pacman_soc_keys_pio.sv
// Avalon-MM input PIO for push-buttons: debounced DATA, sticky edge capture and maskable IRQ.
module pacman_soc_keys_pio
  import pacman_soc_pio_pkg::*;
#(
  parameter int               WIDTH           = 4,
  parameter int               DEBOUNCE_CYCLES = 16,
  parameter int               EDGE_TYPE       = 1,
  parameter logic [WIDTH-1:0] RESET_LEVEL     = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam edge_type_e EDGE_SEL = edge_type_e'(2'(EDGE_TYPE));

  logic [WIDTH-1:0] state_s;
  logic [WIDTH-1:0] edge_s;
  logic [WIDTH-1:0] clr_s;
  logic [WIDTH-1:0] state_prev_q;
  logic [WIDTH-1:0] irq_mask_q;
  logic [WIDTH-1:0] irq_mask_d;
  logic [WIDTH-1:0] edge_cap_q;
  logic [WIDTH-1:0] edge_cap_d;
  logic             wr_en_s;
  logic             unused_wdata_s;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pacman_soc_pio_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (RESET_LEVEL[i])
    ) u_debounce (
      .clk_i    (clk),
      .reset_i  (reset),
      .in_bit_i (in_port[i]),
      .state_o  (state_s[i])
    );
  end

  assign wr_en_s        = chipselect & ~write_n;
  assign unused_wdata_s = ^writedata;

  always_comb begin
    edge_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      edge_s[i] = edge_hit(state_prev_q[i], state_s[i], EDGE_SEL);
    end
  end

  // A newly detected edge is OR-ed in after the clear, so set beats write-1-to-clear.
  always_comb begin
    irq_mask_d = irq_mask_q;
    clr_s      = '0;
    if (wr_en_s && address == PIO_ADDR_IRQMASK) begin
      irq_mask_d = writedata[WIDTH-1:0];
    end else if (wr_en_s && address == PIO_ADDR_EDGECAP) begin
      clr_s = writedata[WIDTH-1:0];
    end else begin
      clr_s = '0;
    end
    edge_cap_d = (edge_cap_q & ~clr_s) | edge_s;
  end

  // The delayed copy resets to the debounced reset level so release makes no edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_prev_q <= RESET_LEVEL;
      irq_mask_q   <= '0;
      edge_cap_q   <= '0;
    end else begin
      state_prev_q <= state_s;
      irq_mask_q   <= irq_mask_d;
      edge_cap_q   <= edge_cap_d;
    end
  end

  always_comb begin
    readdata = 32'd0;
    case (address)
      PIO_ADDR_DATA:    readdata[WIDTH-1:0] = state_s;
      PIO_ADDR_RSVD:    readdata = 32'd0;
      PIO_ADDR_IRQMASK: readdata[WIDTH-1:0] = irq_mask_q;
      PIO_ADDR_EDGECAP: readdata[WIDTH-1:0] = edge_cap_q;
      default:          readdata = 32'd0;
    endcase
  end

  assign irq = |(edge_cap_q & irq_mask_q);

endmodule

// File: tb/tb_pacman_soc_keys_pio.sv
// Scoreboard bench for pacman_soc_keys_pio: directed key stimulus, expected reads queued, monitor compares.
module tb_pacman_soc_keys_pio;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [3:0]  in_port;
  logic        irq;

  logic        chk_req = 1'b0;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] exp_data_q[$];
  logic        exp_irq_q[$];
  string       exp_name_q[$];

  pacman_soc_keys_pio #(
    .WIDTH           (4),
    .DEBOUNCE_CYCLES (4),
    .EDGE_TYPE       (1),
    .RESET_LEVEL     (4'hF)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Present a read for one cycle and queue what it must return.
  task automatic check(input logic [1:0] a, input logic [31:0] d, input logic i, input string nm);
    address = a;
    exp_data_q.push_back(d);
    exp_irq_q.push_back(i);
    exp_name_q.push_back(nm);
    chk_req = 1'b1;
    tick(1);
    chk_req = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    address    = a;
    writedata  = d;
    chipselect = 1'b1;
    write_n    = 1'b0;
    tick(1);
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
  endtask

  // Monitor: compare readdata and irq at mid-cycle whenever a read is presented.
  always @(negedge clk) begin
    if (chk_req) begin
      checks++;
      if (exp_data_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_read: actual data=%08h irq=%0b, required none queued", readdata, irq);
      end else begin
        logic [31:0] ed;
        logic        ei;
        string       nm;
        ed = exp_data_q.pop_front();
        ei = exp_irq_q.pop_front();
        nm = exp_name_q.pop_front();
        if (readdata !== ed || irq !== ei) begin
          errors++;
          $display("FAIL %s: actual data=%08h irq=%0b, required data=%08h irq=%0b",
                   nm, readdata, irq, ed, ei);
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    address    = 2'd0;
    chipselect = 1'b0;
    write_n    = 1'b1;
    writedata  = 32'd0;
    in_port    = 4'hF;
    tick(3);
    reset = 1'b0;

    check(2'd0, 32'h0000000F, 1'b0, "rst_data");
    check(2'd3, 32'h00000000, 1'b0, "rst_edgecap");
    check(2'd2, 32'h00000000, 1'b0, "rst_irqmask");
    check(2'd1, 32'h00000000, 1'b0, "rsvd_zero");
    tick(3);
    check(2'd3, 32'h00000000, 1'b0, "no_cap_on_release");

    // bit 0 falls: state changes exactly 6 edges after the input does
    in_port = 4'hE;
    tick(5);
    check(2'd0, 32'h0000000F, 1'b0, "deb_not_yet");
    check(2'd0, 32'h0000000E, 1'b0, "deb_at_6");
    check(2'd3, 32'h00000001, 1'b0, "cap_fall_b0");
    tick(3);
    in_port = 4'hF;
    tick(8);
    check(2'd0, 32'h0000000F, 1'b0, "deb_rise_b0");
    check(2'd3, 32'h00000001, 1'b0, "rise_not_capt");

    // 3-cycle low glitch on bit 1 is one short of the debounce window
    in_port = 4'hD;
    tick(3);
    in_port = 4'hF;
    tick(8);
    check(2'd0, 32'h0000000F, 1'b0, "glitch_data");
    check(2'd3, 32'h00000001, 1'b0, "glitch_cap");

    wr(2'd2, 32'h00000001);
    check(2'd2, 32'h00000001, 1'b1, "mask_irq_on");
    wr(2'd0, 32'h00000000);
    check(2'd0, 32'h0000000F, 1'b1, "data_wr_ignored");
    wr(2'd3, 32'h00000001);
    check(2'd3, 32'h00000000, 1'b0, "w1c_irq_off");

    // bit 2 falling edge captured on the same edge as its clear write
    in_port = 4'hB;
    tick(6);
    wr(2'd3, 32'h00000004);
    check(2'd3, 32'h00000004, 1'b0, "set_wins");
    check(2'd0, 32'h0000000B, 1'b0, "data_b2_low");
    wr(2'd2, 32'h00000004);
    check(2'd2, 32'h00000004, 1'b1, "mask_b2_irq");
    wr(2'd3, 32'h00000004);
    check(2'd3, 32'h00000000, 1'b0, "clear_b2");
    in_port = 4'hF;
    tick(8);
    check(2'd0, 32'h0000000F, 1'b0, "data_restored");

    // pending capture plus bit 3 mid-debounce, then reset
    wr(2'd2, 32'h00000001);
    in_port = 4'hE;
    tick(7);
    check(2'd3, 32'h00000001, 1'b1, "pending_irq");
    in_port = 4'h6;
    tick(4);
    reset   = 1'b1;
    in_port = 4'h7;
    tick(1);
    check(2'd0, 32'h0000000F, 1'b0, "rst_mid_data");
    check(2'd3, 32'h00000000, 1'b0, "rst_mid_cap");
    check(2'd2, 32'h00000000, 1'b0, "rst_mid_mask");
    reset = 1'b0;
    tick(5);
    check(2'd0, 32'h0000000F, 1'b0, "cnt_cleared_5");
    check(2'd0, 32'h00000007, 1'b0, "cnt_cleared_6");
    check(2'd3, 32'h00000008, 1'b0, "cap_b3_nomask");

    for (int k = 0; k < 20 && exp_data_q.size() != 0; k++) tick(1);
    if (exp_data_q.size() != 0) begin
      errors++;
      $display("FAIL drain: actual %0d pending, required 0", exp_data_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
